oram_avalon_bridge: RTL and testbench
=====================================

# oram_avalon_bridge

Avalon-MM slave front end that sits directly upstream of `oram_module` and replaces the pass-through glue with a handshaked, one-outstanding-request bridge. It holds each accepted request until `oram_module` answers with `output_ready`, returns read data through `readdatavalid`, and applies `byteenable` by read-modify-write, because the ORAM tree only moves whole blocks. It also watches for a stalled ORAM response and records a sticky timeout.

## Interface
Parameters:
- `ADDRESS_WIDTH`, 4, Avalon byte-address width.
- `BYTE_WIDTH`, 8, bits per byte.
- `BYTES_PER_WORD`, 4, bytes per Avalon word. Equals bytes per ORAM block.
- `MEMORY_SIZE`, `1<<ADDRESS_WIDTH`, memory size in bytes.
- `TREE_DEPTH`, `$clog2(MEMORY_SIZE/BYTES_PER_WORD)`, number of block-number bits.
- `TIMEOUT_CYCLES`, 1024, maximum wait for `output_ready`. 0 disables the watchdog.

Ports:
- `clock` in, 1. The only clock.
- `reset` in, 1. Asynchronous, active-high.
- `avs_a_address` in, `ADDRESS_WIDTH`. Byte address.
- `avs_a_byteenable` in, `BYTES_PER_WORD`. Write byte lanes.
- `avs_a_read` / `avs_a_write` in, 1 each. Command strobes.
- `avs_a_writedata` in, `[BYTES_PER_WORD][BYTE_WIDTH]`. Write data.
- `avs_a_waitrequest` out, 1. High while a request is in flight.
- `avs_a_readdata` out, `[BYTES_PER_WORD][BYTE_WIDTH]`. Read data.
- `avs_a_readdatavalid` out, 1. One-cycle read-data strobe.
- `avs_a_response` out, 2. 00 = OKAY, 10 = SLAVEERROR. Valid together with `readdatavalid`.
- `rw_block_number` out, `TREE_DEPTH`. Block number to the ORAM.
- `w_value` out, `BYTE_WIDTH*BYTES_PER_WORD`. Write data to the ORAM.
- `rw_indicator` out, 1. 1 = write, 0 = read.
- `input_ready` out, 1. One-cycle request pulse to the ORAM.
- `r_value` in, `BYTE_WIDTH*BYTES_PER_WORD`. Read data from the ORAM.
- `output_ready` in, 1. One-cycle completion strobe from the ORAM, for reads and writes.
- `timeout_error` out, 1. Sticky; cleared only by `reset`.

## Operation
- Block number is `avs_a_address[ADDRESS_WIDTH-1 -: TREE_DEPTH]`. Low address bits are ignored.
- States: IDLE, RD_WAIT, MERGE, WR_WAIT.
- IDLE: `waitrequest` is low. A command is accepted in any cycle with `read` or `write` high. The bridge captures the address, data, byteenable and command.
  - Write with all lanes enabled → WR_WAIT.
  - Write with some but not all lanes enabled → RD_WAIT, marked as read-modify-write.
  - Write with `byteenable` = 0 → no-op, stays in IDLE.
  - Read → RD_WAIT. `byteenable` is ignored; the full word is returned.
  - `read` and `write` high together → treated as a write; the read is dropped.
- On entering RD_WAIT or WR_WAIT, `input_ready` pulses in the first cycle of the state, with `rw_indicator` and `rw_block_number` held stable for the whole state.
- RD_WAIT, on `output_ready`:
  - Plain read → IDLE. In the next cycle `readdatavalid` = 1, `readdata` = `r_value` (registered), `response` = 00.
  - Read-modify-write → MERGE. The bridge latches `r_value`.
- MERGE, one cycle: merged lane i = `writedata[i]` if `byteenable[i]`, otherwise the latched lane i. Then → WR_WAIT.
- WR_WAIT, on `output_ready` → IDLE. No `readdatavalid` is issued; writes are posted.
- `output_ready` in IDLE or MERGE is ignored.
- Watchdog:
  - The counter clears on entering RD_WAIT or WR_WAIT and increments each cycle spent waiting.
  - When it reaches `TIMEOUT_CYCLES`: set `timeout_error` and go to IDLE.
  - If the aborted transaction was a plain read, issue `readdatavalid` with `readdata` = 0 and `response` = 10. Aborted writes and read-modify-writes only set the flag.

## Timing
- Reset values: state IDLE; `waitrequest`, `readdatavalid`, `input_ready`, `rw_indicator`, `timeout_error` = 0; `readdata`, `w_value`, `rw_block_number` = 0; `response` = 00.
- Accept at edge 0. `waitrequest` is high from cycle 1 until the cycle after the final `output_ready`.
- Read latency: `readdatavalid` is high exactly 1 cycle after `output_ready`. `waitrequest` falls in that same cycle.
- A new command can be accepted in the same cycle `readdatavalid` is high.
- `reset` mid-transaction: immediate return to IDLE with all outputs at reset values. Any in-flight ORAM result is lost; the caller owns resetting `oram_module` too.
- At most one request is outstanding; back-pressure is `waitrequest` only.

## Structure
- `oram_pkg`: state enum, `RESP_OKAY` / `RESP_SLAVEERROR` constants.
- Sub-module `oram_byte_merge`: registered lane merge used by MERGE. It latches `r_value` on a load strobe and presents the merged word.

## Test plan
Settings: ADDRESS_WIDTH=4, BYTES_PER_WORD=4, TREE_DEPTH=2, ORAM model with 5-cycle latency.
- Full write: addr 4'h8, be 4'hF, data 32'hDEADBEEF → one `input_ready` pulse, `rw_indicator`=1, `rw_block_number`=2, `w_value`=32'hDEADBEEF. `waitrequest` is high for 6 cycles.
- Read: read of addr 4'h8 → `readdatavalid` 1 cycle after `output_ready`, `readdata`=32'hDEADBEEF, `response`=00.
- Partial write: be 4'b0011, data 32'h00001234 to block 2 → read pulse, then write pulse with `w_value`=32'hDEAD1234. A later read returns 32'hDEAD1234.
- Timeout: TIMEOUT_CYCLES=8, model never answers, read of block 1 → after 8 waiting cycles `readdatavalid` with data 0, `response`=10, `timeout_error` sticky at 1. A following write then completes normally.
- Edge cases: write with be=0 → no ORAM traffic and `waitrequest` stays low. `read` and `write` together → exactly one write pulse. Stray `output_ready` in IDLE → no output change.
- Reset mid-operation: async `reset` during WR_WAIT → outputs at reset values within the same cycle. The next read is accepted normally.

Source files
------------

// File: rtl/oram_pkg.sv
// Shared types and constants for the Avalon-MM front end of oram_module.
package oram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_MERGE   = 2'd2,
        ST_WR_WAIT = 2'd3
    } oram_state_e;

    localparam logic [1:0] RESP_OKAY       = 2'b00;
    localparam logic [1:0] RESP_SLAVEERROR = 2'b10;

endpackage

// File: rtl/oram_byte_merge.sv
// Holds the block read back during a read-modify-write and overlays the
// enabled write lanes on it.
module oram_byte_merge
    import oram_pkg::*;
#(
    parameter int BYTE_WIDTH     = 8,
    parameter int BYTES_PER_WORD = 4
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       load_i,
    input  logic [BYTE_WIDTH*BYTES_PER_WORD-1:0]       r_value_i,
    input  logic [BYTES_PER_WORD-1:0]                  byteenable_i,
    input  logic [BYTES_PER_WORD-1:0][BYTE_WIDTH-1:0]  writedata_i,
    output logic [BYTES_PER_WORD-1:0][BYTE_WIDTH-1:0]  merged_o
);

    logic [BYTES_PER_WORD-1:0][BYTE_WIDTH-1:0] latched_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            latched_q <= '0;
        end else if (load_i) begin
            latched_q <= r_value_i;
        end
    end

    always_comb begin
        merged_o = latched_q;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (byteenable_i[i]) begin
                merged_o[i] = writedata_i[i];
            end
        end
    end

endmodule

// File: rtl/oram_avalon_bridge.sv
// Avalon-MM slave bridge to oram_module: one outstanding request, byte-lane
// writes via read-modify-write, and a sticky watchdog on the ORAM response.
module oram_avalon_bridge
    import oram_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 4,
    parameter int BYTE_WIDTH     = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int MEMORY_SIZE    = 1 << ADDRESS_WIDTH,
    parameter int TREE_DEPTH     = $clog2(MEMORY_SIZE / BYTES_PER_WORD),
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic [ADDRESS_WIDTH-1:0]                   avs_a_address,
    input  logic [BYTES_PER_WORD-1:0]                  avs_a_byteenable,
    input  logic                                       avs_a_read,
    input  logic                                       avs_a_write,
    input  logic [BYTES_PER_WORD-1:0][BYTE_WIDTH-1:0]  avs_a_writedata,
    output logic                                       avs_a_waitrequest,
    output logic [BYTES_PER_WORD-1:0][BYTE_WIDTH-1:0]  avs_a_readdata,
    output logic                                       avs_a_readdatavalid,
    output logic [1:0]                                 avs_a_response,
    output logic [TREE_DEPTH-1:0]                      rw_block_number,
    output logic [BYTE_WIDTH*BYTES_PER_WORD-1:0]       w_value,
    output logic                                       rw_indicator,
    output logic                                       input_ready,
    input  logic [BYTE_WIDTH*BYTES_PER_WORD-1:0]       r_value,
    input  logic                                       output_ready,
    output logic                                       timeout_error
);

    localparam int WORD_W = BYTE_WIDTH * BYTES_PER_WORD;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    oram_state_e                                state_q;
    logic [TREE_DEPTH-1:0]                      blk_q;
    logic [BYTES_PER_WORD-1:0][BYTE_WIDTH-1:0]  wdata_q;
    logic [BYTES_PER_WORD-1:0]                  be_q;
    logic                                       rmw_q;
    logic [CNT_W-1:0]                           cnt_q;
    logic                                       waitreq_q;
    logic [BYTES_PER_WORD-1:0][BYTE_WIDTH-1:0]  rdata_q;
    logic                                       rdv_q;
    logic [1:0]                                 resp_q;
    logic [WORD_W-1:0]                          wval_q;
    logic                                       rwind_q;
    logic                                       irdy_q;
    logic                                       tmo_q;

    logic [BYTES_PER_WORD-1:0][BYTE_WIDTH-1:0]  merged;
    logic                                       merge_load;
    logic                                       timeout_hit;
    logic [TREE_DEPTH-1:0]                      addr_blk;

    // Only the block-number bits of the byte address reach the ORAM.
    assign addr_blk    = avs_a_address[ADDRESS_WIDTH-1 -: TREE_DEPTH];
    wire   unused_addr = ^avs_a_address[ADDRESS_WIDTH-TREE_DEPTH-1:0];

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);
    assign merge_load  = (state_q == ST_RD_WAIT) && output_ready && rmw_q;

    oram_byte_merge #(
        .BYTE_WIDTH     (BYTE_WIDTH),
        .BYTES_PER_WORD (BYTES_PER_WORD)
    ) u_merge (
        .clk_i        (clock),
        .rst_i        (reset),
        .load_i       (merge_load),
        .r_value_i    (r_value),
        .byteenable_i (be_q),
        .writedata_i  (wdata_q),
        .merged_o     (merged)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            blk_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rmw_q     <= 1'b0;
            cnt_q     <= '0;
            waitreq_q <= 1'b0;
            rdata_q   <= '0;
            rdv_q     <= 1'b0;
            resp_q    <= RESP_OKAY;
            wval_q    <= '0;
            rwind_q   <= 1'b0;
            irdy_q    <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            irdy_q <= 1'b0;
            rdv_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A simultaneous read/write is a write; be=0 writes are dropped.
                    if (avs_a_write) begin
                        if (avs_a_byteenable != '0) begin
                            blk_q     <= addr_blk;
                            wdata_q   <= avs_a_writedata;
                            be_q      <= avs_a_byteenable;
                            cnt_q     <= '0;
                            waitreq_q <= 1'b1;
                            irdy_q    <= 1'b1;
                            if (&avs_a_byteenable) begin
                                wval_q  <= avs_a_writedata;
                                rwind_q <= 1'b1;
                                rmw_q   <= 1'b0;
                                state_q <= ST_WR_WAIT;
                            end else begin
                                rwind_q <= 1'b0;
                                rmw_q   <= 1'b1;
                                state_q <= ST_RD_WAIT;
                            end
                        end
                    end else if (avs_a_read) begin
                        blk_q     <= addr_blk;
                        cnt_q     <= '0;
                        waitreq_q <= 1'b1;
                        irdy_q    <= 1'b1;
                        rwind_q   <= 1'b0;
                        rmw_q     <= 1'b0;
                        state_q   <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (output_ready) begin
                        if (rmw_q) begin
                            state_q <= ST_MERGE;
                        end else begin
                            state_q   <= ST_IDLE;
                            waitreq_q <= 1'b0;
                            rdv_q     <= 1'b1;
                            rdata_q   <= r_value;
                            resp_q    <= RESP_OKAY;
                        end
                    end else if (timeout_hit) begin
                        tmo_q     <= 1'b1;
                        state_q   <= ST_IDLE;
                        waitreq_q <= 1'b0;
                        if (!rmw_q) begin
                            rdv_q   <= 1'b1;
                            rdata_q <= '0;
                            resp_q  <= RESP_SLAVEERROR;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_MERGE: begin
                    wval_q  <= merged;
                    rwind_q <= 1'b1;
                    irdy_q  <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= ST_WR_WAIT;
                end
                ST_WR_WAIT: begin
                    if (output_ready) begin
                        state_q   <= ST_IDLE;
                        waitreq_q <= 1'b0;
                    end else if (timeout_hit) begin
                        tmo_q     <= 1'b1;
                        state_q   <= ST_IDLE;
                        waitreq_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign avs_a_waitrequest   = waitreq_q;
    assign avs_a_readdata      = rdata_q;
    assign avs_a_readdatavalid = rdv_q;
    assign avs_a_response      = resp_q;
    assign rw_block_number     = blk_q;
    assign w_value             = wval_q;
    assign rw_indicator        = rwind_q;
    assign input_ready         = irdy_q;
    assign timeout_error       = tmo_q;

endmodule

// File: tb/tb_oram_avalon_bridge.sv
// Directed bench for oram_avalon_bridge against a 5-cycle-latency ORAM model.
module tb_oram_avalon_bridge;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        avs_a_address = '0;
    logic [3:0]        avs_a_byteenable = '0;
    logic              avs_a_read = 1'b0;
    logic              avs_a_write = 1'b0;
    logic [3:0][7:0]   avs_a_writedata = '0;
    logic              avs_a_waitrequest;
    logic [3:0][7:0]   avs_a_readdata;
    logic              avs_a_readdatavalid;
    logic [1:0]        avs_a_response;
    logic [1:0]        rw_block_number;
    logic [31:0]       w_value;
    logic              rw_indicator;
    logic              input_ready;
    logic [31:0]       r_value = '0;
    logic              output_ready = 1'b0;
    logic              timeout_error;

    oram_avalon_bridge #(
        .ADDRESS_WIDTH  (4),
        .BYTE_WIDTH     (8),
        .BYTES_PER_WORD (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .avs_a_address       (avs_a_address),
        .avs_a_byteenable    (avs_a_byteenable),
        .avs_a_read          (avs_a_read),
        .avs_a_write         (avs_a_write),
        .avs_a_writedata     (avs_a_writedata),
        .avs_a_waitrequest   (avs_a_waitrequest),
        .avs_a_readdata      (avs_a_readdata),
        .avs_a_readdatavalid (avs_a_readdatavalid),
        .avs_a_response      (avs_a_response),
        .rw_block_number     (rw_block_number),
        .w_value             (w_value),
        .rw_indicator        (rw_indicator),
        .input_ready         (input_ready),
        .r_value             (r_value),
        .output_ready        (output_ready),
        .timeout_error       (timeout_error)
    );

    initial forever #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ORAM model: answers 5 cycles after the request pulse.
    logic [31:0] mem [4] = '{default: 32'h0};
    logic        mute = 1'b0;
    int          stray_cnt = 0;
    initial begin
        int          m_cnt;
        int          stray_seen;
        logic        m_rw;
        logic [1:0]  m_blk;
        logic [31:0] m_wv;
        m_cnt = 0; stray_seen = 0; m_rw = 0; m_blk = 0; m_wv = 0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) begin
                m_cnt = 0;
                output_ready = 1'b0;
            end else begin
                output_ready = 1'b0;
                if (stray_cnt != stray_seen) begin
                    stray_seen = stray_cnt;
                    output_ready = 1'b1;
                end
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        output_ready = 1'b1;
                        if (m_rw) mem[m_blk] = m_wv;
                        else      r_value = mem[m_blk];
                    end
                end
                if (input_ready && !mute) begin
                    m_cnt = 5;
                    m_rw  = rw_indicator;
                    m_blk = rw_block_number;
                    m_wv  = w_value;
                end
            end
        end
    end

    // Monitor, sampled on the inactive edge.
    int          cyc = 0, or_cyc = 0;
    int          ir_cnt = 0, wr_cyc = 0, rdv_cnt = 0, rd_lat = 0;
    logic        last_rw = 0, rd_wreq = 0;
    logic [1:0]  last_blk = 0, rd_resp = 0;
    logic [31:0] last_wval = 0, rd_data = 0;
    initial forever begin
        @(negedge clock);
        cyc++;
        if (output_ready) or_cyc = cyc;
        if (input_ready) begin
            ir_cnt++;
            last_rw   = rw_indicator;
            last_blk  = rw_block_number;
            last_wval = w_value;
        end
        if (avs_a_waitrequest) wr_cyc++;
        if (avs_a_readdatavalid) begin
            rdv_cnt++;
            rd_data = avs_a_readdata;
            rd_resp = avs_a_response;
            rd_lat  = cyc - or_cyc;
            rd_wreq = avs_a_waitrequest;
        end
    end

    int ir0, wr0, rdv0;
    task automatic snap();
        ir0 = ir_cnt; wr0 = wr_cyc; rdv0 = rdv_cnt;
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [3:0] addr,
                         input logic [3:0] be, input logic [31:0] data);
        @(negedge clock);
        avs_a_read = rd; avs_a_write = wr; avs_a_address = addr;
        avs_a_byteenable = be; avs_a_writedata = data;
        @(negedge clock);
        avs_a_read = 1'b0; avs_a_write = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 60 && avs_a_waitrequest; n++) @(negedge clock);
        check("idle_bound", avs_a_waitrequest, 1'b0);
        repeat (2) @(negedge clock);
    endtask

    task automatic do_read(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        snap();
        issue(1'b1, 1'b0, addr, 4'h0, 32'h0);
        wait_idle();
        check({tag, "_rdv"},  rdv_cnt - rdv0, 1);
        check({tag, "_data"}, rd_data, exp);
        check({tag, "_resp"}, rd_resp, 2'b00);
        check({tag, "_lat"},  rd_lat, 1);
        check({tag, "_wreq"}, rd_wreq, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_wreq", avs_a_waitrequest, 0);
        check("rst_rdv",  avs_a_readdatavalid, 0);
        check("rst_irdy", input_ready, 0);
        check("rst_rwi",  rw_indicator, 0);
        check("rst_tmo",  timeout_error, 0);
        check("rst_rdata", avs_a_readdata, 0);
        check("rst_wval", w_value, 0);
        check("rst_blk",  rw_block_number, 0);
        check("rst_resp", avs_a_response, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Full-word write
        snap();
        issue(1'b0, 1'b1, 4'h8, 4'hF, 32'hDEADBEEF);
        wait_idle();
        check("fw_pulses", ir_cnt - ir0, 1);
        check("fw_rwi",    last_rw, 1);
        check("fw_blk",    last_blk, 2);
        check("fw_wval",   last_wval, 32'hDEADBEEF);
        check("fw_wcyc",   wr_cyc - wr0, 6);
        check("fw_rdv",    rdv_cnt - rdv0, 0);

        do_read("rd1", 4'h8, 32'hDEADBEEF);
        check("rd1_rwi", last_rw, 0);

        // Partial write: read pulse then merged write pulse
        snap();
        issue(1'b0, 1'b1, 4'h9, 4'b0011, 32'h00001234);
        wait_idle();
        check("pw_pulses", ir_cnt - ir0, 2);
        check("pw_rwi",    last_rw, 1);
        check("pw_wval",   last_wval, 32'hDEAD1234);
        check("pw_rdv",    rdv_cnt - rdv0, 0);
        do_read("rd2", 4'h8, 32'hDEAD1234);

        // Watchdog abort of a plain read
        mute = 1'b1;
        snap();
        issue(1'b1, 1'b0, 4'h4, 4'h0, 32'h0);
        wait_idle();
        mute = 1'b0;
        check("to_blk",  last_blk, 1);
        check("to_wcyc", wr_cyc - wr0, 8);
        check("to_rdv",  rdv_cnt - rdv0, 1);
        check("to_data", rd_data, 0);
        check("to_resp", rd_resp, 2'b10);
        check("to_flag", timeout_error, 1);
        snap();
        issue(1'b0, 1'b1, 4'h0, 4'hF, 32'h11223344);
        wait_idle();
        check("to_wr_pulses", ir_cnt - ir0, 1);
        check("to_wr_wcyc",   wr_cyc - wr0, 6);
        check("to_sticky",    timeout_error, 1);
        do_read("rd3", 4'h0, 32'h11223344);

        // byteenable = 0 write is a no-op
        snap();
        issue(1'b0, 1'b1, 4'h0, 4'h0, 32'hFFFFFFFF);
        repeat (4) @(negedge clock);
        check("be0_pulses", ir_cnt - ir0, 0);
        check("be0_wcyc",   wr_cyc - wr0, 0);

        // read and write together -> one write
        snap();
        issue(1'b1, 1'b1, 4'hC, 4'hF, 32'hCAFEF00D);
        wait_idle();
        check("rw_pulses", ir_cnt - ir0, 1);
        check("rw_rwi",    last_rw, 1);
        check("rw_rdv",    rdv_cnt - rdv0, 0);
        do_read("rd4", 4'hC, 32'hCAFEF00D);

        // Stray output_ready in IDLE
        snap();
        stray_cnt++;
        repeat (4) @(negedge clock);
        check("stray_rdv",   rdv_cnt - rdv0, 0);
        check("stray_rdata", avs_a_readdata, 32'hCAFEF00D);
        check("stray_wreq",  avs_a_waitrequest, 0);
        check("stray_pulse", ir_cnt - ir0, 0);

        // Asynchronous reset during WR_WAIT
        issue(1'b0, 1'b1, 4'h4, 4'hF, 32'h55AA55AA);
        @(negedge clock);
        check("mid_wreq_pre", avs_a_waitrequest, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_wreq",  avs_a_waitrequest, 0);
        check("mid_rwi",   rw_indicator, 0);
        check("mid_wval",  w_value, 0);
        check("mid_blk",   rw_block_number, 0);
        check("mid_irdy",  input_ready, 0);
        check("mid_tmo",   timeout_error, 0);
        check("mid_rdata", avs_a_readdata, 0);
        check("mid_resp",  avs_a_response, 0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        do_read("rd5", 4'h8, 32'hDEAD1234);
        do_read("rd6", 4'h4, 32'h00000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "bench time limit reached");
    end

endmodule
